// File: rtl/vga_line_fetch_if.sv
// Frame-buffer read port of the VGA line-prefetch stage.
// One word per accepted request; rdata is valid in the cycle ack is high.
interface vga_line_fetch_if #(
  parameter int ADDR_W = 15
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [5:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/vga_line_fetch.sv
// Prefetches one 200-pixel source row ahead of the beam into a ping-pong line
// buffer and replays it 4x upscaled, aligned with a 2-cycle delayed display enable.
module vga_line_fetch #(
  parameter int H_VISIBLE = 800,
  parameter int H_TOTAL   = 1056,
  parameter int V_VISIBLE = 600,
  parameter int V_TOTAL   = 628,
  parameter int FB_W      = 200,
  parameter int FB_H      = 150,
  parameter int ADDR_W    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  input  logic             display_on,
  vga_line_fetch_if.master mem,
  output logic [5:0]       pixel_out,
  output logic             display_on_d,
  output logic             underrun
);

  localparam logic [10:0] H_VIS_C  = 11'(H_VISIBLE);
  localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VISIBLE);
  localparam logic [9:0]  V_TOT_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [8:0]  FB_H_C   = 9'(FB_H);
  localparam logic [7:0]  COL_LAST = 8'(FB_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // row*FB_W as shift-and-add (FB_W = 128 + 64 + 8), truncated to the address width
  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] row);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 6) + (r << 3);
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        row_r;
  logic [7:0]        row_s;
  logic [7:0]        col_r;
  logic [7:0]        col_s;
  logic              req_r;
  logic              req_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic              wr_en_s;
  logic              last_ack_s;

  logic              sel_r;
  logic              done_r;
  logic              underrun_r;

  logic [5:0]        buf0 [FB_W];
  logic [5:0]        buf1 [FB_W];
  logic [7:0]        rd_idx_s;
  logic              rd_en_s;
  logic [5:0]        rd_r;
  logic              don_d1_r;
  logic              don_d2_r;
  logic [5:0]        pixel_r;

  logic              pos_ok_s;
  logic [8:0]        next_row_s;
  logic              t1_s;
  logic              t0_s;
  logic              s1_s;
  logic              s0_s;
  logic              swap_s;
  logic              done_eff_s;

  // Out-of-range counter values never trigger a fetch or a swap
  assign pos_ok_s   = (hcount < H_TOT_C) && (vcount < V_TOT_C);
  assign next_row_s = {1'b0, vcount[9:2]} + 9'd1;

  assign t1_s = pos_ok_s && (hcount == 11'd0) && (vcount < V_VIS_C)
                && (vcount[1:0] == 2'd0) && (next_row_s < FB_H_C);
  assign t0_s = pos_ok_s && (hcount == 11'd0) && (vcount == V_VIS_C);
  assign s1_s = pos_ok_s && (hcount == H_VIS_C) && (vcount < V_VIS_C)
                && (vcount[1:0] == 2'd3) && (next_row_s < FB_H_C);
  assign s0_s = pos_ok_s && (hcount == H_VIS_C) && (vcount == V_LAST_C);

  assign swap_s     = s1_s | s0_s;
  assign done_eff_s = done_r | last_ack_s;

  // Fetch FSM next-state, row/column bookkeeping and next request/address
  always_comb begin
    state_s    = state_r;
    row_s      = row_r;
    col_s      = col_r;
    wr_en_s    = 1'b0;
    last_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (t1_s) begin
          row_s   = next_row_s[7:0];
          col_s   = 8'd0;
          state_s = FETCH;
        end else if (t0_s) begin
          row_s   = 8'd0;
          col_s   = 8'd0;
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          wr_en_s = 1'b1;
          if (col_r == COL_LAST) begin
            last_ack_s = 1'b1;
            state_s    = IDLE;
          end else begin
            col_s = col_r + 8'd1;
          end
        end else begin
          state_s = FETCH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_s  = (state_s == FETCH);
    addr_s = row_base(row_s) + ADDR_W'(col_s);
  end

  // FSM state and registered memory-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      row_r   <= 8'd0;
      col_r   <= 8'd0;
      req_r   <= 1'b0;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      col_r   <= col_s;
      req_r   <= req_s;
      if (req_s) begin
        addr_r <= addr_s;
      end
    end
  end

  // Accepted words land in the back buffer (the one not selected for display)
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      if (sel_r) begin
        buf0[col_r] <= mem.mem_rdata;
      end else begin
        buf1[col_r] <= mem.mem_rdata;
      end
    end
  end

  // Buffer swap; a final ack coinciding with the swap still counts as done
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r      <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else if (swap_s) begin
      if (!done_eff_s) begin
        underrun_r <= 1'b1;
      end
      sel_r  <= ~sel_r;
      done_r <= 1'b0;
    end else if (last_ack_s) begin
      done_r <= 1'b1;
    end
  end

  assign rd_en_s  = (hcount < H_VIS_C);
  assign rd_idx_s = hcount[9:2];

  // Synchronous line-buffer read from the front buffer (display latency stage 1)
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      rd_r <= sel_r ? buf1[rd_idx_s] : buf0[rd_idx_s];
    end
  end

  // Enable delay line and blanked output register (display latency stage 2)
  always_ff @(posedge clk) begin
    if (reset) begin
      don_d1_r <= 1'b0;
      don_d2_r <= 1'b0;
      pixel_r  <= 6'd0;
    end else begin
      don_d1_r <= display_on;
      don_d2_r <= don_d1_r;
      pixel_r  <= don_d1_r ? rd_r : 6'd0;
    end
  end

  assign mem.mem_req  = req_r;
  assign mem.mem_addr = addr_r;
  assign pixel_out    = pixel_r;
  assign display_on_d = don_d2_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: stimulus pushes expected addresses and
// pixels, a negedge monitor pops them whenever the DUT presents a handshake or pixel.
module tb_vga_line_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic        display_on = 1'b0;
  logic [5:0]  pixel_out;
  logic        display_on_d;
  logic        underrun;

  int n_cmp = 0;
  int n_fail = 0;
  int req_cycles = 0;
  int ack_mode = 0;
  int ack_wait = 0;

  logic [14:0] addr_q [$];
  logic [5:0]  px_q [$];

  vga_line_fetch_if #(.ADDR_W(15)) mif ();

  // Frame buffer contents: word k holds k mod 64
  assign mif.mem_rdata = mif.mem_addr[5:0];

  vga_line_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .display_on   (display_on),
    .mem          (mif),
    .pixel_out    (pixel_out),
    .display_on_d (display_on_d),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted request and every output pixel is scored here
  always @(negedge clk) begin
    if (mif.mem_req) req_cycles++;
    if (!reset && mif.mem_req && mif.mem_ack) begin
      if (addr_q.size() == 0) check("unexpected_req", int'(mif.mem_addr), -1);
      else check("mem_addr", int'(mif.mem_addr), int'(addr_q.pop_front()));
    end
    if (display_on_d) begin
      if (px_q.size() == 0) check("unexpected_pixel", int'(pixel_out), -1);
      else check("pixel", int'(pixel_out), int'(px_q.pop_front()));
    end else begin
      check("blank_pixel", int'(pixel_out), 0);
    end
  end

  task automatic tick(input int h, input int v, input logic don);
    logic req_b;
    logic ack_b;
    hcount     = 11'(h);
    vcount     = 10'(v);
    display_on = don;
    case (ack_mode)
      0: mif.mem_ack = 1'b1;
      1: mif.mem_ack = mif.mem_req && (ack_wait == 2);
      default: mif.mem_ack = 1'b0;
    endcase
    req_b = mif.mem_req;
    ack_b = mif.mem_ack;
    @(posedge clk);
    #1;
    if (ack_b || !req_b) ack_wait = 0;
    else ack_wait++;
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < 200; c++) addr_q.push_back(15'(r * 200 + c));
  endtask

  task automatic run_span(input int v, input int h0, input int h1, input logic disp, input int row);
    for (int h = h0; h <= h1; h++) begin
      logic on;
      on = disp && (h < 800) && (v < 600);
      if (on) px_q.push_back(6'((row * 200 + h / 4) % 64));
      tick(h, v, on);
    end
  endtask

  initial begin
    mif.mem_ack = 1'b0;
    // Reset state
    reset = 1'b1;
    tick(5, 610, 1'b0);
    tick(5, 610, 1'b0);
    reset = 1'b0;
    check("rst_mem_req", int'(mif.mem_req), 0);
    check("rst_mem_addr", int'(mif.mem_addr), 0);
    check("rst_pixel_out", int'(pixel_out), 0);
    check("rst_display_on_d", int'(display_on_d), 0);
    check("rst_underrun", int'(underrun), 0);

    // Reset in the middle of a row-0 fetch discards it
    push_row(0);
    tick(0, 600, 1'b0);
    check("t0_req_next_cycle", int'(mif.mem_req), 1);
    check("t0_first_addr", int'(mif.mem_addr), 0);
    run_span(600, 1, 10, 1'b0, 0);
    reset = 1'b1;
    tick(11, 600, 1'b0);
    tick(11, 600, 1'b0);
    reset = 1'b0;
    addr_q.delete();
    check("midfetch_rst_req", int'(mif.mem_req), 0);
    check("midfetch_rst_pixel", int'(pixel_out), 0);
    check("midfetch_rst_underrun", int'(underrun), 0);
    tick(12, 600, 1'b0);
    check("no_resume_after_rst", int'(mif.mem_req), 0);

    // Row-0 prefetch, final ack lands in the same cycle as the S0 swap
    push_row(0);
    req_cycles = 0;
    tick(0, 600, 1'b0);
    run_span(600, 1, 199, 1'b0, 0);
    tick(800, 627, 1'b0);
    check("s0_final_ack_req_drop", int'(mif.mem_req), 0);
    check("row0_fetch_len", req_cycles, 200);
    check("s0_same_cycle_no_underrun", int'(underrun), 0);

    // Zero-wait fetch of row 1 while rows 0..3 of the display show row 0
    req_cycles = 0;
    push_row(1);
    run_span(0, 0, 0, 1'b1, 0);
    check("t1_req", int'(mif.mem_req), 1);
    check("t1_first_addr", int'(mif.mem_addr), 200);
    run_span(0, 1, 1055, 1'b1, 0);
    check("row1_fetch_len", req_cycles, 200);
    for (int v = 1; v < 4; v++) run_span(v, 0, 1055, 1'b1, 0);
    check("row1_no_underrun", int'(underrun), 0);

    // Wait states: ack every 3rd cycle, row 2 takes 600 cycles
    ack_mode = 1;
    req_cycles = 0;
    push_row(2);
    run_span(4, 0, 2, 1'b1, 1);
    check("hold_addr_3cyc", int'(mif.mem_addr), 400);
    run_span(4, 3, 3, 1'b1, 1);
    check("addr_after_ack", int'(mif.mem_addr), 401);
    run_span(4, 4, 1055, 1'b1, 1);
    for (int v = 5; v < 8; v++) run_span(v, 0, 1055, 1'b1, 1);
    check("row2_fetch_len", req_cycles, 600);
    check("row2_no_underrun", int'(underrun), 0);
    push_row(3);
    run_span(8, 0, 1055, 1'b1, 2);
    run_span(11, 795, 805, 1'b0, 0);
    check("row3_no_underrun", int'(underrun), 0);

    // Underrun: a fresh frame, then ack held low from vcount 4
    ack_mode = 0;
    push_row(0);
    run_span(600, 0, 210, 1'b0, 0);
    run_span(627, 799, 801, 1'b0, 0);
    push_row(1);
    run_span(0, 0, 210, 1'b0, 0);
    run_span(3, 799, 801, 1'b0, 0);
    check("pre_stall_no_underrun", int'(underrun), 0);
    ack_mode = 2;
    run_span(4, 0, 20, 1'b0, 0);
    check("stall_req_held", int'(mif.mem_req), 1);
    check("stall_addr_held", int'(mif.mem_addr), 400);
    run_span(7, 795, 799, 1'b0, 0);
    check("underrun_before_swap", int'(underrun), 0);
    run_span(7, 800, 800, 1'b0, 0);
    check("underrun_at_v7_h800", int'(underrun), 1);
    run_span(8, 0, 1, 1'b0, 0);
    check("trigger_ignored_in_fetch", int'(mif.mem_addr), 400);
    run_span(627, 799, 801, 1'b0, 0);
    run_span(0, 0, 5, 1'b0, 0);
    check("underrun_sticky", int'(underrun), 1);

    // Reset during a stalled fetch
    reset = 1'b1;
    tick(3, 10, 1'b0);
    tick(3, 10, 1'b0);
    reset = 1'b0;
    check("final_rst_req", int'(mif.mem_req), 0);
    check("final_rst_underrun", int'(underrun), 0);
    check("final_rst_pixel", int'(pixel_out), 0);
    tick(3, 10, 1'b0);
    check("final_rst_req_stays", int'(mif.mem_req), 0);
    check("addr_queue_drained", addr_q.size(), 0);
    check("pixel_queue_drained", px_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
